// File: rtl/eth_send_arbiter_if.sv
// Handshake bundle between the Rx/FireWire requesters, the send arbiter and EthernetIO.
// The master modport is the arbiter side.
interface eth_send_arbiter_if;
   logic        respReq;
   logic [15:0] respByteCount;
   logic        fwdReq;
   logic [15:0] fwdByteCount;
   logic        fwdAck;
   logic        sendRequest;
   logic        sendBusy;
   logic        isForward;
   logic [15:0] txByteCount;
   logic        rxHold;

   modport master (
      input  respReq, respByteCount, fwdReq, fwdByteCount, sendBusy,
      output fwdAck, sendRequest, isForward, txByteCount, rxHold
   );

   modport slave (
      output respReq, respByteCount, fwdReq, fwdByteCount, sendBusy,
      input  fwdAck, sendRequest, isForward, txByteCount, rxHold
   );
endinterface

// File: rtl/eth_send_arbiter.sv
// Real-time Ethernet Tx arbiter between Rx responses and FireWire forwards, with grant
// timeout and inter-packet gap. Optional debug counters/registers: ETH_ARB_DEBUG_EN.
module eth_send_arbiter #(
   parameter int unsigned GAP_CYCLES    = 12,
   parameter int unsigned GRANT_TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               clearErrors,
   eth_send_arbiter_if.master bus,
   output logic               timeoutErr,
   output logic               overrunErr,
   input  logic [15:0]        reg_raddr,
   output logic [31:0]        reg_rdata
);
   typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, BUSY = 2'd2, GAP = 2'd3} state_t;

   localparam logic [7:0] GAP_LD = 8'(GAP_CYCLES);
   localparam logic [7:0] TMO    = 8'(GRANT_TIMEOUT);

   state_t      state;
   logic [7:0]  cnt;
   logic [7:0]  cnt_inc;
   logic        resp_pend;
   logic        fwd_starved;
   logic [15:0] resp_len;
   logic        send_request;
   logic        fwd_ack;
   logic        is_forward;
   logic [15:0] tx_byte_count;
   logic        rx_hold;
   logic        grant_req;
   logic        resp_win;
   logic        tmo_hit;

   assign cnt_inc   = cnt + 8'd1;
   assign grant_req = (state == IDLE) && (resp_pend || bus.fwdReq);
   // A starved forward beats a pending response exactly once.
   assign resp_win  = resp_pend && !(fwd_starved && bus.fwdReq);
   assign tmo_hit   = (state == GRANT) && !bus.sendBusy && (cnt_inc == TMO);
   assign rx_hold   = resp_pend && (state != IDLE);

   assign bus.sendRequest = send_request;
   assign bus.fwdAck      = fwd_ack;
   assign bus.isForward   = is_forward;
   assign bus.txByteCount = tx_byte_count;
   assign bus.rxHold      = rx_hold;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state         <= IDLE;
         cnt           <= '0;
         resp_pend     <= 1'b0;
         fwd_starved   <= 1'b0;
         resp_len      <= '0;
         send_request  <= 1'b0;
         fwd_ack       <= 1'b0;
         is_forward    <= 1'b0;
         tx_byte_count <= '0;
         timeoutErr    <= 1'b0;
         overrunErr    <= 1'b0;
      end else begin
         fwd_ack <= 1'b0;
         if (clearErrors) begin
            timeoutErr <= 1'b0;
            overrunErr <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (grant_req) begin
                  send_request <= 1'b1;
                  cnt          <= '0;
                  state        <= GRANT;
                  if (resp_win) begin
                     is_forward    <= 1'b0;
                     tx_byte_count <= resp_len;
                     resp_pend     <= 1'b0;
                     if (bus.fwdReq) fwd_starved <= 1'b1;
                  end else begin
                     is_forward    <= 1'b1;
                     tx_byte_count <= bus.fwdByteCount;
                     fwd_ack       <= 1'b1;
                     fwd_starved   <= 1'b0;
                  end
               end
            end
            GRANT: begin
               if (bus.sendBusy) begin
                  send_request <= 1'b0;
                  state        <= BUSY;
               end else if (tmo_hit) begin
                  send_request <= 1'b0;
                  timeoutErr   <= 1'b1;
                  if (!is_forward) resp_pend <= 1'b0;
                  cnt          <= GAP_LD;
                  state        <= GAP;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            BUSY: begin
               if (!bus.sendBusy) begin
                  cnt   <= GAP_LD;
                  state <= GAP;
               end
            end
            GAP: begin
               if (cnt == 8'd0) begin
                  is_forward <= 1'b0;
                  state      <= IDLE;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
         // New response request overrides any clear above; errors beat clearErrors.
         if (bus.respReq) begin
            resp_pend <= 1'b1;
            resp_len  <= bus.respByteCount;
            if (resp_pend) overrunErr <= 1'b1;
         end
      end
   end

`ifdef ETH_ARB_DEBUG_EN
   logic [7:0] num_resp;
   logic [7:0] num_fwd;
   logic [7:0] num_timeout;
   logic       unused_raddr;

   assign unused_raddr = ^{reg_raddr[15:8], reg_raddr[3:2]};

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         num_resp    <= '0;
         num_fwd     <= '0;
         num_timeout <= '0;
         reg_rdata   <= '0;
      end else begin
         if (grant_req && resp_win)  num_resp    <= num_resp + 8'd1;
         if (grant_req && !resp_win) num_fwd     <= num_fwd + 8'd1;
         if (tmo_hit)                num_timeout <= num_timeout + 8'd1;
         if (reg_raddr[7:4] == 4'hb) begin
            case (reg_raddr[1:0])
               2'd0:    reg_rdata <= 32'h4142_5242;
               2'd1:    reg_rdata <= {2'b00, state, resp_pend, fwd_starved, rx_hold, is_forward,
                                      8'd0, tx_byte_count};
               2'd2:    reg_rdata <= {num_timeout, num_fwd, num_resp, 6'd0, overrunErr, timeoutErr};
               default: reg_rdata <= '0;
            endcase
         end else begin
            reg_rdata <= '0;
         end
      end
   end
`else
   logic unused_raddr;
   assign unused_raddr = ^reg_raddr;
   assign reg_rdata    = '0;
`endif
endmodule

// File: tb/tb_eth_send_arbiter.sv
// Directed bench for eth_send_arbiter: a vector table for the first response transfer,
// then hand-written sequences for gap, starvation, overrun, timeout, reset and debug reads.
module tb_eth_send_arbiter;
   logic        clk = 1'b0;
   logic        rstn = 1'b1;
   logic        clearErrors = 1'b0;
   logic        timeoutErr;
   logic        overrunErr;
   logic [15:0] reg_raddr = 16'h0000;
   logic [31:0] reg_rdata;
   int          checks = 0;
   int          errors = 0;

   eth_send_arbiter_if bus ();

   eth_send_arbiter dut (
      .clk         (clk),
      .rstn        (rstn),
      .clearErrors (clearErrors),
      .bus         (bus),
      .timeoutErr  (timeoutErr),
      .overrunErr  (overrunErr),
      .reg_raddr   (reg_raddr),
      .reg_rdata   (reg_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        resp_req;
      logic [15:0] resp_bc;
      logic        busy;
      logic        sr;
      logic        ack;
      logic        isf;
      logic [15:0] tx;
      logic        rx;
   } vec_t;

   vec_t tbl[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic finish_xfer();
      bus.sendBusy = 1'b1;
      step();
      bus.sendBusy = 1'b0;
      step();
      repeat (13) step();
   endtask

   task automatic grant_resp(input logic [15:0] bc);
      bus.respReq       = 1'b1;
      bus.respByteCount = bc;
      step();
      bus.respReq = 1'b0;
      step();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      tbl[0] = '{1'b1, 16'd64, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0,  1'b0};
      tbl[1] = '{1'b0, 16'd0,  1'b0, 1'b1, 1'b0, 1'b0, 16'd64, 1'b0};
      tbl[2] = '{1'b0, 16'd0,  1'b0, 1'b1, 1'b0, 1'b0, 16'd64, 1'b0};
      tbl[3] = '{1'b0, 16'd0,  1'b0, 1'b1, 1'b0, 1'b0, 16'd64, 1'b0};
      tbl[4] = '{1'b0, 16'd0,  1'b1, 1'b0, 1'b0, 1'b0, 16'd64, 1'b0};

      bus.respReq = 1'b0;
      bus.respByteCount = '0;
      bus.fwdReq = 1'b0;
      bus.fwdByteCount = '0;
      bus.sendBusy = 1'b0;

      // Reset state
      #2 rstn = 1'b0;
      #1;
      chk("rst_sendRequest", bus.sendRequest, 0);
      chk("rst_fwdAck", bus.fwdAck, 0);
      chk("rst_isForward", bus.isForward, 0);
      chk("rst_txByteCount", bus.txByteCount, 0);
      chk("rst_rxHold", bus.rxHold, 0);
      chk("rst_errors", {timeoutErr, overrunErr}, 0);
      chk("rst_rdata", reg_rdata, 0);
      @(negedge clk) rstn = 1'b1;
      step();

      // Response alone: table covers request, grant and first busy cycle
      for (int i = 0; i < 5; i++) begin
         bus.respReq = tbl[i].resp_req;
         bus.respByteCount = tbl[i].resp_bc;
         bus.sendBusy = tbl[i].busy;
         step();
         chk($sformatf("vec%0d_sendRequest", i), bus.sendRequest, tbl[i].sr);
         chk($sformatf("vec%0d_fwdAck", i), bus.fwdAck, tbl[i].ack);
         chk($sformatf("vec%0d_isForward", i), bus.isForward, tbl[i].isf);
         chk($sformatf("vec%0d_txByteCount", i), bus.txByteCount, tbl[i].tx);
         chk($sformatf("vec%0d_rxHold", i), bus.rxHold, tbl[i].rx);
      end

      // Busy held 80 cycles with a forward waiting; forward must wait for the gap
      bus.fwdReq = 1'b1;
      bus.fwdByteCount = 16'd100;
      repeat (79) step();
      chk("busy_hold_sendRequest", bus.sendRequest, 0);
      chk("busy_hold_fwdAck", bus.fwdAck, 0);
      bus.sendBusy = 1'b0;
      step();
      n = 0;
      while (!bus.sendRequest && n < 40) begin
         step();
         n++;
      end
      chk("gap_to_grant_cycles", n, 14);
      chk("fwd_grant_fwdAck", bus.fwdAck, 1);
      chk("fwd_grant_isForward", bus.isForward, 1);
      chk("fwd_grant_txByteCount", bus.txByteCount, 100);
      bus.fwdReq = 1'b0;
      step();
      chk("fwdAck_one_cycle", bus.fwdAck, 0);
      finish_xfer();
      chk("gap_end_isForward", bus.isForward, 0);

      // Simultaneous requests: response first, then the starved forward wins
      bus.respReq = 1'b1;
      bus.respByteCount = 16'd32;
      step();
      bus.respReq = 1'b0;
      bus.fwdReq = 1'b1;
      bus.fwdByteCount = 16'd200;
      step();
      chk("both_first_sendRequest", bus.sendRequest, 1);
      chk("both_first_isForward", bus.isForward, 0);
      chk("both_first_txByteCount", bus.txByteCount, 32);
      chk("both_first_fwdAck", bus.fwdAck, 0);
      bus.respReq = 1'b1;
      bus.respByteCount = 16'd48;
      step();
      bus.respReq = 1'b0;
      chk("second_resp_rxHold", bus.rxHold, 1);
      finish_xfer();
      step();
      chk("starved_fwd_fwdAck", bus.fwdAck, 1);
      chk("starved_fwd_isForward", bus.isForward, 1);
      chk("starved_fwd_txByteCount", bus.txByteCount, 200);
      bus.fwdReq = 1'b0;
      finish_xfer();
      step();
      chk("queued_resp_sendRequest", bus.sendRequest, 1);
      chk("queued_resp_txByteCount", bus.txByteCount, 48);
      chk("queued_resp_isForward", bus.isForward, 0);
      chk("no_overrun_yet", overrunErr, 0);
      finish_xfer();

      // Overrun: two responses during a busy forward
      bus.fwdReq = 1'b1;
      bus.fwdByteCount = 16'd10;
      step();
      bus.fwdReq = 1'b0;
      chk("ovr_fwd_fwdAck", bus.fwdAck, 1);
      bus.sendBusy = 1'b1;
      step();
      bus.respReq = 1'b1;
      bus.respByteCount = 16'd20;
      step();
      bus.respReq = 1'b0;
      step();
      bus.respReq = 1'b1;
      bus.respByteCount = 16'd30;
      step();
      bus.respReq = 1'b0;
      chk("overrunErr_set", overrunErr, 1);
      chk("ovr_rxHold_busy", bus.rxHold, 1);
      bus.sendBusy = 1'b0;
      step();
      repeat (12) step();
      chk("ovr_rxHold_gap", bus.rxHold, 1);
      step();
      step();
      chk("ovr_grant_txByteCount", bus.txByteCount, 30);
      chk("ovr_grant_isForward", bus.isForward, 0);
      chk("ovr_grant_rxHold", bus.rxHold, 0);
      chk("overrunErr_sticky", overrunErr, 1);
      clearErrors = 1'b1;
      step();
      clearErrors = 1'b0;
      chk("overrunErr_cleared", overrunErr, 0);
      finish_xfer();

      // Timeout: sendBusy never comes
      grant_resp(16'd5);
      n = 1;
      while (bus.sendRequest && n < 300) begin
         step();
         if (bus.sendRequest) n++;
      end
      chk("timeout_high_cycles", n, 255);
      chk("timeoutErr_set", timeoutErr, 1);
      clearErrors = 1'b1;
      step();
      clearErrors = 1'b0;
      chk("timeoutErr_cleared", timeoutErr, 0);
      repeat (12) step();
      bus.fwdReq = 1'b1;
      bus.fwdByteCount = 16'd7;
      step();
      bus.fwdReq = 1'b0;
      chk("tmo2_fwdAck", bus.fwdAck, 1);
      repeat (254) step();
      chk("tmo2_still_requesting", bus.sendRequest, 1);
      clearErrors = 1'b1;
      step();
      clearErrors = 1'b0;
      chk("tmo2_error_beats_clear", timeoutErr, 1);
      chk("tmo2_sendRequest_drop", bus.sendRequest, 0);
      repeat (13) step();

      // Reset mid-transfer
      grant_resp(16'd9);
      bus.sendBusy = 1'b1;
      step();
      bus.respReq = 1'b1;
      bus.respByteCount = 16'd11;
      step();
      bus.respReq = 1'b0;
      chk("pre_reset_rxHold", bus.rxHold, 1);
      #2 rstn = 1'b0;
      #1;
      chk("midrst_sendRequest", bus.sendRequest, 0);
      chk("midrst_isForward", bus.isForward, 0);
      chk("midrst_txByteCount", bus.txByteCount, 0);
      chk("midrst_rxHold", bus.rxHold, 0);
      chk("midrst_timeoutErr", timeoutErr, 0);
      chk("midrst_rdata", reg_rdata, 0);
      bus.sendBusy = 1'b0;
      @(negedge clk) rstn = 1'b1;
      repeat (3) step();
      chk("post_rst_idle_sendRequest", bus.sendRequest, 0);
      bus.fwdReq = 1'b1;
      bus.fwdByteCount = 16'd3;
      step();
      bus.fwdReq = 1'b0;
      chk("post_rst_fwd_grant", {bus.sendRequest, bus.fwdAck}, 2'b11);
      finish_xfer();

      // Grant counting: 3 responses, 2 forwards since reset
      for (int i = 0; i < 3; i++) begin
         grant_resp(16'(i + 1));
         finish_xfer();
      end
      bus.fwdReq = 1'b1;
      step();
      bus.fwdReq = 1'b0;
      finish_xfer();
      reg_raddr = 16'h00b2;
      step();
`ifdef ETH_ARB_DEBUG_EN
      chk("dbg_counters", reg_rdata, 32'h0002_0300);
`else
      chk("dbg_counters_tied", reg_rdata, 32'h0);
`endif
      reg_raddr = 16'h00b0;
      step();
`ifdef ETH_ARB_DEBUG_EN
      chk("dbg_id", reg_rdata, 32'h4142_5242);
`else
      chk("dbg_id_tied", reg_rdata, 32'h0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
